// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clk_gate_ctrl
//  Brief    : Per-domain idle-driven clock gating controller with wake timing.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl #(
    parameter int NUM_DOMAINS = 2,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DOMAINS-1:0] busy,
    input  logic [NUM_DOMAINS-1:0] wake_req,
    input  logic                   disable_gating,
    output logic [NUM_DOMAINS-1:0] pwr_en,
    output logic                   gating_override,
    output logic [NUM_DOMAINS-1:0] ready
);

    localparam int c_idle_w = $clog2(IDLE_CYCLES + 1);
    localparam int c_wake_w = $clog2(WAKE_CYCLES + 1);

    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(IDLE_CYCLES - 1);
    localparam logic [c_idle_w-1:0] c_idle_one  = c_idle_w'(1);
    localparam logic [c_wake_w-1:0] c_wake_last = c_wake_w'(WAKE_CYCLES - 1);
    localparam logic [c_wake_w-1:0] c_wake_one  = c_wake_w'(1);

    localparam logic [1:0] c_st_on   = 2'd0;
    localparam logic [1:0] c_st_off  = 2'd1;
    localparam logic [1:0] c_st_wake = 2'd2;

    logic r_override;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_override <= 1'b1;
        end else begin
            r_override <= disable_gating;
        end
    end

    assign gating_override = r_override;

    generate
        for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_domain
            logic [1:0]          r_state;
            logic [1:0]          w_state_nxt;
            logic [c_idle_w-1:0] r_idle_cnt;
            logic [c_idle_w-1:0] w_idle_nxt;
            logic [c_wake_w-1:0] r_wake_cnt;
            logic [c_wake_w-1:0] w_wake_nxt;
            logic                r_pwr_en;
            logic                r_ready;
            logic                w_idle;

            assign w_idle = ~busy[g] & ~wake_req[g] & ~r_override;

            always_comb begin
                w_state_nxt = r_state;
                w_idle_nxt  = r_idle_cnt;
                w_wake_nxt  = r_wake_cnt;
                case (r_state)
                    c_st_on: begin
                        if (!w_idle) begin
                            w_idle_nxt = '0;
                        end else if (r_idle_cnt == c_idle_last) begin
                            w_state_nxt = c_st_off;
                            w_idle_nxt  = '0;
                        end else begin
                            w_idle_nxt = r_idle_cnt + c_idle_one;
                        end
                    end
                    c_st_off: begin
                        // busy is deliberately ignored: only an explicit wake reopens the clock
                        if (wake_req[g] || r_override) begin
                            w_state_nxt = c_st_wake;
                            w_wake_nxt  = '0;
                        end
                    end
                    c_st_wake: begin
                        if (r_wake_cnt == c_wake_last) begin
                            w_state_nxt = c_st_on;
                            w_idle_nxt  = '0;
                        end else begin
                            w_wake_nxt = r_wake_cnt + c_wake_one;
                        end
                    end
                    default: begin
                        w_state_nxt = c_st_on;
                        w_idle_nxt  = '0;
                        w_wake_nxt  = '0;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state    <= c_st_on;
                    r_idle_cnt <= '0;
                    r_wake_cnt <= '0;
                    r_pwr_en   <= 1'b1;
                    r_ready    <= 1'b1;
                end else begin
                    r_state    <= w_state_nxt;
                    r_idle_cnt <= w_idle_nxt;
                    r_wake_cnt <= w_wake_nxt;
                    r_pwr_en   <= (w_state_nxt != c_st_off);
                    r_ready    <= (w_state_nxt == c_st_on);
                end
            end

            assign pwr_en[g] = r_pwr_en;
            assign ready[g]  = r_ready;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_gate_ctrl
//  Brief    : Directed and randomized checks of clk_gate_ctrl against a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_gate_ctrl;

    localparam int ND = 2;
    localparam int IC = 4;
    localparam int WC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [ND-1:0] busy;
    logic [ND-1:0] wake_req;
    logic          disable_gating;
    logic [ND-1:0] pwr_en;
    logic [ND-1:0] ready;
    logic          gating_override;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: a domain is either gated, or powered with a countdown until ready.
    bit m_gated [ND];
    int m_wake_left [ND];
    int m_idle_run [ND];
    bit m_ovr;

    clk_gate_ctrl #(
        .NUM_DOMAINS (ND),
        .IDLE_CYCLES (IC),
        .WAKE_CYCLES (WC)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .busy            (busy),
        .wake_req        (wake_req),
        .disable_gating  (disable_gating),
        .pwr_en          (pwr_en),
        .gating_override (gating_override),
        .ready           (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [ND-1:0] got, input logic [ND-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int d = 0; d < ND; d++) begin
                m_gated[d]     = 1'b0;
                m_wake_left[d] = 0;
                m_idle_run[d]  = 0;
            end
            m_ovr = 1'b1;
        end else begin
            for (int d = 0; d < ND; d++) begin
                if (m_gated[d]) begin
                    if (wake_req[d] || m_ovr) begin
                        m_gated[d]     = 1'b0;
                        m_wake_left[d] = WC;
                    end
                end else if (m_wake_left[d] > 0) begin
                    m_wake_left[d]--;
                    m_idle_run[d] = 0;
                end else begin
                    if (!busy[d] && !wake_req[d] && !m_ovr) m_idle_run[d]++;
                    else m_idle_run[d] = 0;
                    if (m_idle_run[d] == IC) begin
                        m_gated[d]    = 1'b1;
                        m_idle_run[d] = 0;
                    end
                end
            end
            m_ovr = disable_gating;
        end
    endtask

    task automatic step();
        logic [ND-1:0] e_pwr;
        logic [ND-1:0] e_rdy;
        @(posedge clk);
        model_edge();
        #1;
        for (int d = 0; d < ND; d++) begin
            e_pwr[d] = !m_gated[d];
            e_rdy[d] = !m_gated[d] && (m_wake_left[d] == 0);
        end
        check("model_pwr_en", pwr_en, e_pwr);
        check("model_ready", ready, e_rdy);
        check("model_override", {1'b0, gating_override}, {1'b0, m_ovr});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset          = 1'b1;
        busy           = '0;
        wake_req       = '0;
        disable_gating = 1'b0;
        steps(2);
        check("reset_pwr_en", pwr_en, 2'b11);
        check("reset_ready", ready, 2'b11);
        check("reset_override", {1'b0, gating_override}, 2'b01);

        // Idle gate: first cycle after reset is not idle (override still set)
        reset = 1'b0;
        step();
        check("post_reset_override", {1'b0, gating_override}, 2'b00);
        steps(3);
        check("idle3_pwr_en", pwr_en, 2'b11);
        step();
        check("idle4_pwr_en", pwr_en, 2'b00);
        check("idle4_ready", ready, 2'b00);

        // Wake latency on domain 0
        wake_req = 2'b01;
        step();
        check("wake_pwr_en", pwr_en, 2'b01);
        check("wake_ready0", ready, 2'b00);
        wake_req = 2'b00;
        step();
        check("wake_ready1", ready, 2'b00);
        step();
        check("wake_ready2", ready, 2'b01);

        // Counter restart
        steps(3);
        busy = 2'b01;
        step();
        busy = 2'b00;
        steps(3);
        check("restart_hold", pwr_en, 2'b01);
        step();
        check("restart_gate", pwr_en, 2'b00);

        // Override wakes and holds both domains
        disable_gating = 1'b1;
        step();
        check("ovr_on", {1'b0, gating_override}, 2'b01);
        check("ovr_still_off", pwr_en, 2'b00);
        step();
        check("ovr_wake", pwr_en, 2'b11);
        steps(2);
        check("ovr_ready", ready, 2'b11);
        steps(20);
        check("ovr_hold", pwr_en, 2'b11);
        disable_gating = 1'b0;
        step();
        steps(3);
        check("ovr_release_hold", pwr_en, 2'b11);
        step();
        check("ovr_release_gate", pwr_en, 2'b00);

        // Boundary collision on domain 1
        wake_req = 2'b10;
        step();
        wake_req = 2'b00;
        steps(2);
        check("d1_ready", ready, 2'b10);
        steps(3);
        wake_req = 2'b10;
        step();
        check("collide_stay_on", pwr_en, 2'b10);
        wake_req = 2'b00;
        steps(3);
        check("collide_restart", pwr_en, 2'b10);
        step();
        check("collide_gate", pwr_en, 2'b00);

        // Wake request held through WAKE does not change ready timing
        wake_req = 2'b01;
        step();
        step();
        check("wake_hold_ready1", ready, 2'b00);
        step();
        check("wake_hold_ready2", ready, 2'b01);
        wake_req = 2'b00;

        // Reset during WAKE
        steps(4);
        check("pre_reset_gate", pwr_en, 2'b00);
        wake_req = 2'b01;
        step();
        wake_req = 2'b00;
        reset    = 1'b1;
        step();
        check("midwake_reset_pwr", pwr_en, 2'b11);
        check("midwake_reset_ready", ready, 2'b11);
        check("midwake_reset_ovr", {1'b0, gating_override}, 2'b01);
        reset = 1'b0;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            for (int d = 0; d < ND; d++) begin
                busy[d]     = ($urandom_range(0, 6) == 0);
                wake_req[d] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 39) == 0) disable_gating = ~disable_gating;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001: Parameter NUM_DOMAINS, default 2, SHALL set the number of independently gated clock domains (1..32).
REQ-002: Parameter IDLE_CYCLES, default 16, SHALL set the consecutive idle cycles required before a domain is gated (>=1).
REQ-003: Parameter WAKE_CYCLES, default 4, SHALL set the cycles from pwr_en re-assertion to ready (>=1).
REQ-004: clk  input  1  free-running clock; the only clock; all state SHALL update on its rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: busy  input  NUM_DOMAINS  per-domain activity; 1 = domain has work in flight.
REQ-007: wake_req  input  NUM_DOMAINS  per-domain wake request, driven from ungated logic.
REQ-008: disable_gating  input  1  1 = force all domains clocked.
REQ-009: pwr_en  output  NUM_DOMAINS  per-domain power enable, to the clk_gate pwr_en input.
REQ-010: gating_override  output  1  registered copy of disable_gating, to every clk_gate gating_override input.
REQ-011: ready  output  NUM_DOMAINS  1 = domain clock is stable and the domain may accept work.

Function
REQ-012: Each domain SHALL have an independent FSM with states ON, OFF and WAKE, plus an idle counter and a wake counter, each sized $clog2(max+1) bits.
REQ-013: All outputs SHALL be registered; pwr_en = (state != OFF) and ready = (state == ON).
REQ-014: A cycle is idle for a domain when busy=0 and wake_req=0 for that domain and gating_override=0.
REQ-015: In ON, a non-idle cycle SHALL clear the idle counter; an idle cycle SHALL increment it.
REQ-016: In ON, an idle cycle with idle counter == IDLE_CYCLES-1 SHALL move the domain to OFF, so pwr_en falls on the edge ending the IDLE_CYCLES-th consecutive idle cycle.
REQ-017: In OFF, wake_req=1 or gating_override=1 SHALL move the domain to WAKE on the next edge and clear the wake counter; busy SHALL be ignored in OFF.
REQ-018: In WAKE, the wake counter SHALL increment each cycle; at wake counter == WAKE_CYCLES-1 the domain SHALL move to ON with the idle counter cleared, so ready rises exactly WAKE_CYCLES cycles after pwr_en rises.
REQ-019: In WAKE, wake_req, busy and disable_gating SHALL be ignored; a wake SHALL never be aborted.
REQ-020: wake_req=1 in the same cycle as the final idle count SHALL keep the domain in ON, since that cycle is not idle.
REQ-021: gating_override SHALL follow disable_gating with one cycle of latency; while it is 1, no domain SHALL enter OFF and idle counters SHALL hold at 0.
REQ-022: Domains SHALL NOT interact; simultaneous transitions in different domains SHALL all take effect on the same edge.
REQ-023: Counters SHALL saturate at their terminal value and never wrap.

Reset
REQ-024: reset=1 SHALL put every domain in ON and clear both counters, giving pwr_en all-ones, ready all-ones and gating_override=1 on the following cycle.
REQ-025: gating_override SHALL remain 1 for the first cycle after reset deasserts, then follow disable_gating.
REQ-026: reset asserted in any state, including mid-WAKE or mid-idle-count, SHALL override all other inputs and take effect on the next edge.

Verification
REQ-027: With NUM_DOMAINS=2, IDLE_CYCLES=4 and WAKE_CYCLES=2, the bench SHALL cover the scenarios REQ-028 to REQ-033.
REQ-028: Idle gate: release reset with disable_gating=0 and busy=00, then hold busy=00 -> pwr_en=00 after 4 idle cycles; ready=00 on the same edge.
REQ-029: Wake latency: domain 0 OFF, pulse wake_req=01 for 1 cycle -> pwr_en[0]=1 on the next edge; ready[0]=1 exactly 2 cycles later; domain 1 unchanged.
REQ-030: Counter restart: busy[0]=0 for 3 cycles, busy[0]=1 for 1 cycle, then busy[0]=0 -> pwr_en[0] stays 1 until 4 further idle cycles have elapsed.
REQ-031: Override: both domains OFF, set disable_gating=1 -> gating_override=1 after 1 cycle; both domains enter WAKE the next cycle and reach ON; they stay ON for 20 idle cycles until disable_gating=0, then gate after 4 more.
REQ-032: Boundary collision: wake_req[1]=1 on the 4th idle cycle of domain 1 -> domain 1 stays ON with the idle count restarted; wake_req during WAKE -> no effect on ready timing.
REQ-033: Reset mid-operation: assert reset during WAKE of domain 0 -> next cycle pwr_en=11, ready=11, gating_override=1.
